// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and size-to-byte-mask helper for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    WAIT0,
    ACC1,
    WAIT1,
    RESP
  } lsu_state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  size_mask = 4'b0001;
      SIZE_H:  size_mask = 4'b0011;
      SIZE_W:  size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte mask and shifted write data for stores, and
// shift/truncate/extend of the two-word read window for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata64,
  input  logic        is_unsigned,
  output logic [7:0]  mask,
  output logic [63:0] wdata64,
  output logic [31:0] rdata
);

  logic [63:0] rshift;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                         input logic uns);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] ext;
    b8  = raw[7:0];
    h16 = raw[15:0];
    ext = '0;
    case (sz)
      SIZE_B: begin
        if (uns) ext = signed'(32'(raw[7:0]));
        else     ext = 32'(b8);
      end
      SIZE_H: begin
        if (uns) ext = signed'(32'(raw[15:0]));
        else     ext = 32'(h16);
      end
      SIZE_W:  ext = raw;
      default: ext = '0;
    endcase
    return ext;
  endfunction

  assign mask    = {4'b0000, size_mask(size)} << off;
  assign wdata64 = {32'h0, wdata} << {off, 3'b000};
  assign rshift  = rdata64 >> {off, 3'b000};
  assign rdata   = extend(rshift[31:0], size, is_unsigned);

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit: accepts one core access at a time and drives a word-aligned
// request/grant data-memory port, splitting word-crossing accesses into two words.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MISALIGN_SPLIT = 1,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic              we_p0;
  logic              uns_p0;
  logic              err_p0;
  logic [31:0]       wdata_p0;
  logic [31:0]       lo_p0;
  logic [31:0]       hi_p0;

  logic [1:0]        size_sel;
  logic [1:0]        off_sel;
  logic [7:0]        mask;
  logic [63:0]       wdata64;
  logic [31:0]       load_data;
  logic              split;
  logic              accept;
  logic              bad_req;
  logic [ADDR_W-1:0] word_addr;

  // In IDLE the aligner looks at the incoming request so the split decision is
  // available at acceptance; afterwards it works from the latched request.
  assign size_sel  = (state == IDLE) ? req_size : size_p0;
  assign off_sel   = (state == IDLE) ? req_addr[1:0] : addr_p0[1:0];
  assign split     = |mask[7:4];
  assign accept    = req_valid && (state == IDLE);
  assign bad_req   = (req_size == SIZE_ILL) || (split && (MISALIGN_SPLIT == 0));
  assign word_addr = {addr_p0[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .size        (size_sel),
    .off         (off_sel),
    .wdata       (wdata_p0),
    .rdata64     ({split ? hi_p0 : 32'h0, lo_p0}),
    .is_unsigned (uns_p0),
    .mask        (mask),
    .wdata64     (wdata64),
    .rdata       (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch (p0) and read-word capture
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= req_addr;
      size_p0  <= req_size;
      we_p0    <= req_we;
      uns_p0   <= req_unsigned;
      wdata_p0 <= req_wdata;
      err_p0   <= bad_req;
    end
    if (state == WAIT0 && mem_rvalid) lo_p0 <= mem_rdata;
    if (state == WAIT1 && mem_rvalid) hi_p0 <= mem_rdata;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'h0;
    mem_wdata  = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad_req ? RESP : ACC0;
      end
      ACC0: begin
        mem_req   = 1'b1;
        mem_we    = we_p0;
        mem_addr  = word_addr;
        mem_be    = mask[3:0];
        mem_wdata = wdata64[31:0];
        if (mem_gnt) begin
          if (!we_p0)     state_nxt = WAIT0;
          else if (split) state_nxt = ACC1;
          else            state_nxt = RESP;
        end
      end
      WAIT0: begin
        if (mem_rvalid) state_nxt = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_req   = 1'b1;
        mem_we    = we_p0;
        mem_addr  = word_addr + ADDR_W'(4);
        mem_be    = mask[7:4];
        mem_wdata = wdata64[63:32];
        if (mem_gnt) state_nxt = we_p0 ? RESP : WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_p0;
        resp_rdata = (we_p0 || err_p0) ? 32'h0 : load_data;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed accesses against a word memory model.
module tb_lsu_mem_master;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
  } mem_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        req_valid2, req_ready2, resp_valid2, resp_err2;
  logic [31:0] resp_rdata2;
  logic        mem_req2, mem_we2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [3:0]  mem_be2;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_acc2 = 0;
  int gnt_delay = 0;
  int rvalid_delay = 1;
  int wait_cnt = 0;
  int rd_cnt = 0;
  logic [31:0] rd_data;
  logic [31:0] mem [0:1023];

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  resp_exp_t resp2_q[$];

  logic        stall_v;
  logic [68:0] stall_pl;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_master #(.MISALIGN_SPLIT(1), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_mem_master #(.MISALIGN_SPLIT(0), .ADDR_W(32)) dut_nosplit (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_req(mem_req2), .mem_gnt(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_rvalid(1'b0), .mem_rdata(32'h0)
  );

  // Memory model: grant after gnt_delay stalled cycles, read data rvalid_delay cycles after grant.
  assign mem_gnt    = mem_req && (wait_cnt >= gnt_delay);
  assign mem_rvalid = (rd_cnt == 1);
  assign mem_rdata  = mem_rvalid ? rd_data : 32'h0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_req && !mem_gnt) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_gnt && !mem_we) begin
      rd_cnt  <= rvalid_delay;
      rd_data <= mem[mem_addr[11:2]];
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h040] <= 32'hDEADBEEF;
      mem[10'h0C0] <= 32'h44332211;
      mem[10'h0C1] <= 32'h88776655;
      mem[10'h3FF] <= 32'h7F000000;
      mem[10'h000] <= 32'h00000080;
    end else if (mem_req && mem_gnt && mem_we) begin
      mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_wdata, mem_be);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int lat);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.lat = lat;
    mem_q.push_back(e);
  endtask

  task automatic push_resp(input logic err, input logic [31:0] rdata, input int lat);
    resp_exp_t e;
    e.err = err; e.rdata = rdata; e.lat = lat;
    resp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", req_ready, 1'b1);
    last_acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (resp_q.size() != 0 || mem_q.size() != 0) begin
      check("drain_timeout", resp_q.size() + mem_q.size(), 0);
      resp_q.delete();
      mem_q.delete();
    end
  endtask

  // Memory-side monitor: every granted request is checked against the queue head.
  initial begin
    mem_exp_t e;
    stall_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v) check("stall_stable", {mem_we, mem_addr, mem_be, mem_wdata}, stall_pl);
        if (mem_gnt) begin
          stall_v = 1'b0;
          if (mem_q.size() == 0) begin
            check("mem_req_unexpected", mem_req, 1'b0);
          end else begin
            e = mem_q.pop_front();
            check("mem_we", mem_we, e.we);
            check("mem_addr", mem_addr, e.addr);
            check("mem_be", mem_be, e.be);
            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            if (e.lat >= 0) check("mem_lat", cyc - last_acc, e.lat);
          end
        end else begin
          if (mem_q.size() == 0) check("mem_req_unexpected", mem_req, 1'b0);
          stall_v  = 1'b1;
          stall_pl = {mem_we, mem_addr, mem_be, mem_wdata};
        end
      end
    end
  end

  // Response monitor for both instances.
  initial begin
    resp_exp_t r;
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", resp_valid, 1'b0);
        end else begin
          r = resp_q.pop_front();
          check("resp_err", resp_err, r.err);
          check("resp_rdata", resp_rdata, r.rdata);
          if (r.lat >= 0) check("resp_lat", cyc - last_acc, r.lat);
        end
      end
      if (!reset && resp_valid2) begin
        if (resp2_q.size() == 0) begin
          check("resp2_unexpected", resp_valid2, 1'b0);
        end else begin
          r = resp2_q.pop_front();
          check("resp2_err", resp_err2, r.err);
          check("resp2_rdata", resp_rdata2, r.rdata);
          check("resp2_lat", cyc - last_acc2, r.lat);
        end
      end
      if (!reset && mem_req2) check("nosplit_mem_req", mem_req2, 1'b0);
    end
  end

  initial begin
    int n;
    resp_exp_t r2;
    reset = 1'b1;
    req_valid = 1'b0; req_valid2 = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {resp_valid, resp_err, mem_req, mem_we, mem_be, resp_rdata,
                            mem_addr, mem_wdata}, 104'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    // Aligned word load, zero-wait memory
    push_mem(0, 32'h100, 4'b1111, 0, 1); push_resp(0, 32'hDEADBEEF, 3);
    issue(0, 2'b10, 0, 32'h100, 0); wait_done();

    // Byte and half stores/loads
    push_mem(1, 32'h200, 4'b1000, 32'hA5000000, 1); push_resp(0, 32'h0, 2);
    issue(1, 2'b00, 0, 32'h203, 32'h000000A5); wait_done();
    push_mem(0, 32'h200, 4'b1000, 0, 1); push_resp(0, 32'hFFFFFFA5, 3);
    issue(0, 2'b00, 0, 32'h203, 0); wait_done();
    push_mem(0, 32'h200, 4'b1000, 0, 1); push_resp(0, 32'h000000A5, 3);
    issue(0, 2'b00, 1, 32'h203, 0); wait_done();
    push_mem(1, 32'h200, 4'b1100, 32'h12340000, 1); push_resp(0, 32'h0, 2);
    issue(1, 2'b01, 0, 32'h202, 32'hABCD1234); wait_done();
    push_mem(0, 32'h200, 4'b1100, 0, 1); push_resp(0, 32'h00001234, 3);
    issue(0, 2'b01, 0, 32'h202, 0); wait_done();
    push_mem(1, 32'h200, 4'b0011, 32'h00008001, 1); push_resp(0, 32'h0, 2);
    issue(1, 2'b01, 0, 32'h200, 32'h00008001); wait_done();
    push_mem(0, 32'h200, 4'b0011, 0, 1); push_resp(0, 32'hFFFF8001, 3);
    issue(0, 2'b01, 0, 32'h200, 0); wait_done();
    push_mem(0, 32'h200, 4'b0011, 0, 1); push_resp(0, 32'h00008001, 3);
    issue(0, 2'b01, 1, 32'h200, 0); wait_done();

    // Misaligned split load
    push_mem(0, 32'h300, 4'b1100, 0, 1); push_mem(0, 32'h304, 4'b0011, 0, 3);
    push_resp(0, 32'h66554433, 5);
    issue(0, 2'b10, 0, 32'h302, 0); wait_done();

    // Misaligned split store and readback
    push_mem(1, 32'h3FC, 4'b1000, 32'hBE000000, 1); push_mem(1, 32'h400, 4'b0111, 32'h00CAFEBA, 2);
    push_resp(0, 32'h0, 3);
    issue(1, 2'b10, 0, 32'h3FF, 32'hCAFEBABE); wait_done();
    push_mem(0, 32'h3FC, 4'b1000, 0, 1); push_mem(0, 32'h400, 4'b0111, 0, 3);
    push_resp(0, 32'hCAFEBABE, 5);
    issue(0, 2'b10, 0, 32'h3FF, 0); wait_done();

    // Split half load wrapping past the top of the address space
    push_mem(0, 32'hFFFFFFFC, 4'b1000, 0, 1); push_mem(0, 32'h0, 4'b0001, 0, 3);
    push_resp(0, 32'hFFFF807F, 5);
    issue(0, 2'b01, 0, 32'hFFFFFFFF, 0); wait_done();

    // Illegal size: error, no memory traffic
    push_resp(1, 32'h0, 1);
    issue(0, 2'b11, 0, 32'h100, 0); wait_done();

    // Grant delayed 3 cycles: payload held stable
    gnt_delay = 3;
    push_mem(1, 32'h500, 4'b1111, 32'h11223344, 4); push_resp(0, 32'h0, 5);
    issue(1, 2'b10, 0, 32'h500, 32'h11223344); wait_done();
    gnt_delay = 0;

    // Split disabled instance rejects a word-crossing half load
    r2.err = 1'b1; r2.rdata = 32'h0; r2.lat = 1;
    resp2_q.push_back(r2);
    @(negedge clk);
    req_we = 0; req_size = 2'b01; req_unsigned = 0; req_addr = 32'h103; req_valid2 = 1'b1;
    check("nosplit_ready", req_ready2, 1'b1);
    last_acc2 = cyc;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    n = 0;
    while (resp2_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("nosplit_drain", resp2_q.size(), 0);
    resp2_q.delete();

    // Reset while waiting for read data; late rvalid must be ignored
    rvalid_delay = 5;
    push_mem(0, 32'h100, 4'b1111, 0, 1);
    issue(0, 2'b10, 0, 32'h100, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", req_ready, 1'b1);
    check("no_resp_after_reset", resp_valid, 1'b0);
    repeat (8) @(negedge clk);
    check("mem_q_empty_after_reset", mem_q.size(), 0);
    mem_q.delete();
    rvalid_delay = 1;
    push_mem(0, 32'h304, 4'b1111, 0, 1); push_resp(0, 32'h88776655, 3);
    issue(0, 2'b10, 0, 32'h304, 0); wait_done();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
